fsk_mod_tx: RTL and testbench

Binary FSK modulator: the transmit end of the 2-FSK link whose receiver counts rising edges of the line signal over a fixed symbol window. The block accepts bytes over a valid/ready handshake and serializes them MSB first. Each bit is sent for exactly `SYM_LEN` clocks as a square wave on `y`: the fast tone for bit 0, the slow tone for bit 1. The block sits between the byte source and the line driver. Default parameters match the receiver's decision rule: 20-clock window, more than 4 edges means 0.

---
 rtl/fsk_mod_tx_if.sv | 18 +
 rtl/fsk_mod_tx.sv | 103 ++++++++++
 tb/tb_fsk_mod_tx.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsk_mod_tx_if.sv
// Byte handshake between the byte source (master) and the FSK modulator (slave).
interface fsk_mod_tx_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/fsk_mod_tx.sv
// Binary FSK modulator: serializes bytes MSB first, one square-wave tone per bit on y.
// Optional FSK_MOD_PHASE_CONT_EN keeps tone phase across symbol boundaries.
module fsk_mod_tx #(
    parameter int unsigned SYM_LEN = 20,
    parameter int unsigned HALF0   = 1,
    parameter int unsigned HALF1   = 4
) (
    input  logic         clk,
    input  logic         reset,
    fsk_mod_tx_if.slave  bus,
    output logic         y,
    output logic         busy,
    output logic         sym_strobe
);

    localparam int unsigned SymW  = $clog2(SYM_LEN);
    localparam int unsigned HalfW = $clog2(HALF1) + 1;

    localparam logic [SymW-1:0]  SymLast = SymW'(SYM_LEN - 1);
    localparam logic [HalfW-1:0] Lim0    = HalfW'(HALF0 - 1);
    localparam logic [HalfW-1:0] Lim1    = HalfW'(HALF1 - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e            state;
    logic [7:0]        shreg;
    logic [2:0]        bit_idx;
    logic [SymW-1:0]   sym_cnt;
    logic [HalfW-1:0]  half_cnt;

    logic              sym_end;
    logic              accept;
    logic [HalfW-1:0]  lim;

    assign sym_end       = (sym_cnt == SymLast);
    assign bus.din_ready = (state == StIdle) || ((state == StSend) && (bit_idx == 3'd0) && sym_end);
    assign accept        = bus.din_valid & bus.din_ready;
    assign lim           = shreg[7] ? Lim1 : Lim0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            shreg      <= '0;
            bit_idx    <= '0;
            sym_cnt    <= '0;
            half_cnt   <= '0;
            y          <= 1'b0;
            busy       <= 1'b0;
            sym_strobe <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;
            unique case (state)
                StIdle: begin
                    y        <= 1'b0;
                    half_cnt <= '0;
                    if (accept) begin
                        shreg      <= bus.din;
                        bit_idx    <= 3'd7;
                        sym_cnt    <= '0;
                        state      <= StSend;
                        busy       <= 1'b1;
                        sym_strobe <= 1'b1;
                    end
                end
                StSend: begin
                    if (half_cnt >= lim) begin
                        y        <= ~y;
                        half_cnt <= '0;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end

                    if (!sym_end) begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end else begin
                        sym_cnt <= '0;
`ifndef FSK_MOD_PHASE_CONT_EN
                        // Every symbol starts low with a full half-period.
                        y        <= 1'b0;
                        half_cnt <= '0;
`endif
                        if (bit_idx != 3'd0) begin
                            shreg      <= shreg << 1;
                            bit_idx    <= bit_idx - 3'd1;
                            sym_strobe <= 1'b1;
                        end else if (accept) begin
                            shreg      <= bus.din;
                            bit_idx    <= 3'd7;
                            sym_strobe <= 1'b1;
                        end else begin
                            state    <= StIdle;
                            y        <= 1'b0;
                            half_cnt <= '0;
                            busy     <= 1'b0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_mod_tx.sv
// Directed self-checking bench for fsk_mod_tx at default parameters (20/1/4).
module tb_fsk_mod_tx;

    localparam int CapLen = 400;

    logic clk = 1'b0;
    logic reset;
    logic y, busy, sym_strobe;

    fsk_mod_tx_if bus ();

    fsk_mod_tx #(
        .SYM_LEN(20),
        .HALF0  (1),
        .HALF1  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .y         (y),
        .busy      (busy),
        .sym_strobe(sym_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic cap_y [CapLen];
    logic cap_s [CapLen];
    logic cap_b [CapLen];
    logic cap_r [CapLen];
    logic y_before;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts b0, then records one sample per cycle starting in the first symbol cycle.
    // mode 0: single byte; 1: back-to-back with b1; 2: backpressure with 8'h5A queued.
    task automatic run(input logic [7:0] b0, input logic [7:0] b1, input int mode, input int n);
        logic acc;
        for (int i = 0; i < CapLen; i++) begin
            cap_y[i] = 1'b0;
            cap_s[i] = 1'b0;
            cap_b[i] = 1'b0;
            cap_r[i] = 1'b0;
        end
        bus.din       = b0;
        bus.din_valid = 1'b1;
        y_before      = y;
        tick();
        if (mode == 1) bus.din = b1;
        else bus.din_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mode == 2 && i >= 30 && i < 159) begin
                bus.din_valid = 1'b1;
                bus.din       = 8'(i * 37 + 1);
            end
            if (mode == 2 && i == 159) bus.din = 8'h5A;
            cap_y[i] = y;
            cap_s[i] = sym_strobe;
            cap_b[i] = busy;
            cap_r[i] = bus.din_ready;
            acc = bus.din_valid & bus.din_ready;
            tick();
            if (acc && mode != 0) bus.din_valid = 1'b0;
        end
    endtask

    function automatic int rises(input int start, input int len);
        int   cnt  = 0;
        logic prev = (start == 0) ? y_before : cap_y[start-1];
        for (int j = start; j < start + len && j < CapLen; j++) begin
            if (cap_y[j] && !prev) cnt++;
            prev = cap_y[j];
        end
        return cnt;
    endfunction

    // Edge-counting receiver with its window aligned to sym_strobe: >4 edges decodes as 0.
    function automatic logic [7:0] decode(input int first_sym);
        logic [7:0] d  = 8'h00;
        int         sc = 0;
        for (int i = 0; i < CapLen; i++) begin
            if (cap_s[i]) begin
                if (sc >= first_sym && sc < first_sym + 8) d = {d[6:0], (rises(i, 20) > 4) ? 1'b0 : 1'b1};
                sc++;
            end
        end
        return d;
    endfunction

    task automatic test_reset();
        reset         = 1'b1;
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        #1;
        checks++;
        if ({y, busy, sym_strobe, bus.din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0001", {y, busy, sym_strobe, bus.din_ready});
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({y, busy, sym_strobe, bus.din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 0001", {y, busy, sym_strobe, bus.din_ready});
        end
    endtask

    task automatic test_single_byte();
        int   busy_cnt = 0;
        int   bad_s    = -1;
        logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run(8'hA5, 8'h00, 0, 170);
        for (int i = 0; i < 170; i++) begin
            if (cap_b[i]) busy_cnt++;
            if (bad_s < 0 && cap_s[i] !== ((i % 20 == 0) && (i < 160))) bad_s = i;
        end
        checks++;
        if (busy_cnt != 160 || cap_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_len: got %0d first %b expected 160 first 1", busy_cnt, cap_b[0]);
        end
        checks++;
        if (bad_s >= 0) begin
            errors++;
            $display("FAIL single_strobes: wrong sym_strobe %b at cycle %0d", cap_s[bad_s], bad_s);
        end
        for (int s = 0; s < 8; s++) begin
            int c = rises(s * 20, 20);
            checks++;
            if (exp_bits[s] ? (c < 2 || c > 3) : (c != 10)) begin
                errors++;
                $display("FAIL single_edges_sym%0d: got %0d expected %s", s, c,
                         exp_bits[s] ? "2..3" : "10");
            end
        end
        checks++;
        if ({cap_y[160], cap_b[160], cap_r[160]} !== 3'b001) begin
            errors++;
            $display("FAIL single_after: y/busy/ready got %b expected 001",
                     {cap_y[160], cap_b[160], cap_r[160]});
        end
    endtask

    task automatic test_back_to_back();
        int first_ready = -1;
        int bad_s       = -1;
        int busy_cnt    = 0;
        int bad_e       = -1;
        run(8'h00, 8'hFF, 1, 330);
        for (int i = 0; i < 330; i++) begin
            if (first_ready < 0 && cap_r[i]) first_ready = i;
            if (bad_s < 0 && cap_s[i] !== ((i % 20 == 0) && (i < 320))) bad_s = i;
            if (i < 320 && cap_b[i]) busy_cnt++;
        end
        checks++;
        if (first_ready != 159) begin
            errors++;
            $display("FAIL b2b_second_accept: ready first at %0d expected 159", first_ready);
        end
        checks++;
        if (bad_s >= 0 || busy_cnt != 320 || cap_b[320] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_contiguous: strobe err at %0d busy %0d end %b expected -1 320 0",
                     bad_s, busy_cnt, cap_b[320]);
        end
        for (int s = 0; s < 16; s++) begin
            int c = rises(s * 20, 20);
            if (bad_e < 0 && ((s < 8) ? (c != 10) : (c < 2 || c > 3))) bad_e = s;
        end
        checks++;
        if (bad_e >= 0) begin
            errors++;
            $display("FAIL b2b_edges: symbol %0d got %0d edges expected %s", bad_e,
                     rises(bad_e * 20, 20), (bad_e < 8) ? "10" : "2..3");
        end
    endtask

    task automatic test_loopback();
        logic [7:0] got;
        run(8'h3C, 8'h00, 0, 170);
        got = decode(0);
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("FAIL loopback_3c: got %h expected 3c", got);
        end
    endtask

    task automatic test_backpressure();
        int         early = 0;
        logic [7:0] b0, b1;
        run(8'hC3, 8'h00, 2, 330);
        for (int i = 0; i < 159; i++) if (cap_r[i]) early++;
        checks++;
        if (early != 0 || cap_r[159] !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready: early ready %0d last %b expected 0 1", early, cap_r[159]);
        end
        b0 = decode(0);
        b1 = decode(8);
        checks++;
        if (b0 !== 8'hC3) begin
            errors++;
            $display("FAIL bp_first_byte: got %h expected c3", b0);
        end
        checks++;
        if (b1 !== 8'h5A) begin
            errors++;
            $display("FAIL bp_second_byte: got %h expected 5a", b1);
        end
    endtask

    task automatic test_async_reset();
        logic       busy_pre;
        logic [7:0] got;
        int         nstr = 0;
        bus.din       = 8'hA5;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        repeat (70) tick();
        busy_pre = busy;
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({busy_pre, y, busy, sym_strobe, bus.din_ready} !== 5'b10001) begin
            errors++;
            $display("FAIL async_reset: busy_pre/y/busy/strobe/ready got %b expected 10001",
                     {busy_pre, y, busy, sym_strobe, bus.din_ready});
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({y, busy, bus.din_ready} !== 3'b001) begin
            errors++;
            $display("FAIL async_reset_idle: y/busy/ready got %b expected 001", {y, busy, bus.din_ready});
        end
        run(8'h3C, 8'h00, 0, 170);
        got = decode(0);
        for (int i = 0; i < 170; i++) if (cap_s[i]) nstr++;
        checks++;
        if (got !== 8'h3C || nstr != 8 || cap_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_resend: got %h strobes %0d first %b expected 3c 8 1", got, nstr, cap_s[0]);
        end
    endtask

    task automatic test_mode();
        int   sc = 0;
        int   bad = -1;
        logic exp_y [8];
`ifdef FSK_MOD_PHASE_CONT_EN
        exp_y = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_y = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        run(8'h55, 8'h00, 0, 170);
        for (int i = 0; i < 170; i++) begin
            if (cap_s[i]) begin
                if (bad < 0 && (sc >= 8 || cap_y[i] !== exp_y[sc])) bad = sc;
                sc++;
            end
        end
        checks++;
        if (bad >= 0 || sc != 8) begin
            errors++;
            $display("FAIL mode_strobe_y: first bad symbol %0d strobes %0d expected -1 8", bad, sc);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_loopback();
        test_backpressure();
        test_async_reset();
        test_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
